// File: rtl/sram_access_ctrl.sv
// Request sequencer for a single-port compiled SRAM macro: registers address/data,
// drives write_en/sense_en pulses with fixed timing and returns read words on a valid/ready channel.
module sram_access_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int WR_CYCLES    = 1,
  parameter int SENSE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              sram_write_en,
  output logic              sram_sense_en
);

  typedef enum logic [2:0] {IDLE, SETUP, WRITE, SENSE, RESP} state_t;

  // Counters are loaded with N-1 so a phase lasts exactly N enable cycles.
  localparam logic [3:0] WR_LOAD    = 4'(WR_CYCLES - 1);
  localparam logic [3:0] SENSE_LOAD = 4'(SENSE_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                we_reg, we_next;
  logic                req_ready_reg, req_ready_next;
  logic                rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic                wr_done_reg, wr_done_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   din_reg, din_next;
  logic                write_en_reg, write_en_next;
  logic                sense_en_reg, sense_en_next;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    we_next        = we_reg;
    req_ready_next = req_ready_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    wr_done_next   = 1'b0;
    addr_next      = addr_reg;
    din_next       = din_reg;
    write_en_next  = 1'b0;
    sense_en_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        req_ready_next = 1'b1;
        if (req_valid && req_ready_reg) begin
          addr_next      = req_addr;
          if (req_we) din_next = req_wdata;
          we_next        = req_we;
          req_ready_next = 1'b0;
          state_next     = SETUP;
        end
      end
      SETUP: begin
        // Enables are registered, so they are raised on the edge leaving SETUP.
        if (we_reg) begin
          write_en_next = 1'b1;
          cnt_next      = WR_LOAD;
          state_next    = WRITE;
        end else begin
          sense_en_next = 1'b1;
          cnt_next      = SENSE_LOAD;
          state_next    = SENSE;
        end
      end
      WRITE: begin
        if (cnt_reg == 4'd0) begin
          wr_done_next   = 1'b1;
          req_ready_next = 1'b1;
          state_next     = IDLE;
        end else begin
          write_en_next = 1'b1;
          cnt_next      = cnt_reg - 4'd1;
        end
      end
      SENSE: begin
        if (cnt_reg == 4'd0) begin
          rsp_rdata_next = sram_dout;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else begin
          sense_en_next = 1'b1;
          cnt_next      = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          req_ready_next = 1'b1;
          state_next     = IDLE;
        end
      end
      default: begin
        req_ready_next = 1'b1;
        rsp_valid_next = 1'b0;
        state_next     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      we_reg        <= 1'b0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      wr_done_reg   <= 1'b0;
      addr_reg      <= '0;
      din_reg       <= '0;
      write_en_reg  <= 1'b0;
      sense_en_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      we_reg        <= we_next;
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      wr_done_reg   <= wr_done_next;
      addr_reg      <= addr_next;
      din_reg       <= din_next;
      write_en_reg  <= write_en_next;
      sense_en_reg  <= sense_en_next;
    end
  end

  assign req_ready     = req_ready_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_rdata     = rsp_rdata_reg;
  assign wr_done       = wr_done_reg;
  assign sram_addr     = addr_reg;
  assign sram_din      = din_reg;
  assign sram_write_en = write_en_reg;
  assign sram_sense_en = sense_en_reg;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a behavioural 256x32 array model on the SRAM pins.
module tb_sram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        wr_done;
  logic [7:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;
  logic        sram_write_en;
  logic        sram_sense_en;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cycle     = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  sram_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .wr_done(wr_done),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .sram_write_en(sram_write_en), .sram_sense_en(sram_sense_en)
  );

  // Array model: write on the clock while write_en is high; dout only valid while sensing.
  always @(posedge clk) if (sram_write_en) mem[sram_addr] <= sram_din;
  assign sram_dout = sram_sense_en ? mem[sram_addr] : 32'h0;

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Setup helper: issue a write from IDLE and wait for its completion pulse.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    int n;
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0;
    n = 0;
    while (!wr_done && n < 20) begin step(); n++; end
    total_cnt++;
    if (wr_done !== 1'b1) $display("FAIL setup_write_done: got %b want 1 (addr %h)", wr_done, a);
    else pass_cnt++;
    $display("write addr=%h data=%h cycle=%0d", a, d, cycle);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'hAA; req_wdata = 32'h55555555;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if ({req_ready, rsp_valid, wr_done, sram_write_en, sram_sense_en} !== 5'b10000)
        $display("FAIL reset_ctrl: got %b want 10000", {req_ready, rsp_valid, wr_done, sram_write_en, sram_sense_en});
      else pass_cnt++;
      total_cnt++;
      if ({sram_addr, sram_din, rsp_rdata} !== 72'h0)
        $display("FAIL reset_data: got %h want 0", {sram_addr, sram_din, rsp_rdata});
      else pass_cnt++;
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", req_ready);
    else pass_cnt++;
    $display("reset released cycle=%0d", cycle);
  endtask

  task automatic test_single_write();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h5A; req_wdata = 32'hDEADBEEF;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL wr_ready_n: got %b want 1", req_ready);
    else pass_cnt++;
    step(); // N+1
    req_valid = 1'b0;
    total_cnt++;
    if ({sram_addr, sram_din} !== {8'h5A, 32'hDEADBEEF})
      $display("FAIL wr_addr_din: got %h want %h", {sram_addr, sram_din}, {8'h5A, 32'hDEADBEEF});
    else pass_cnt++;
    total_cnt++;
    if ({req_ready, sram_write_en, sram_sense_en, wr_done} !== 4'b0000)
      $display("FAIL wr_setup: got %b want 0000", {req_ready, sram_write_en, sram_sense_en, wr_done});
    else pass_cnt++;
    step(); // N+2
    total_cnt++;
    if ({sram_write_en, sram_sense_en, wr_done} !== 3'b100)
      $display("FAIL wr_pulse: got %b want 100", {sram_write_en, sram_sense_en, wr_done});
    else pass_cnt++;
    step(); // N+3
    total_cnt++;
    if ({sram_write_en, sram_sense_en, wr_done, req_ready} !== 4'b0011)
      $display("FAIL wr_done_pulse: got %b want 0011", {sram_write_en, sram_sense_en, wr_done, req_ready});
    else pass_cnt++;
    step(); // N+4
    total_cnt++;
    if ({sram_write_en, wr_done} !== 2'b00)
      $display("FAIL wr_done_clear: got %b want 00", {sram_write_en, wr_done});
    else pass_cnt++;
    total_cnt++;
    if (mem[8'h5A] !== 32'hDEADBEEF) $display("FAIL wr_array: got %h want DEADBEEF", mem[8'h5A]);
    else pass_cnt++;
    $display("write addr=5a data=deadbeef cycle=%0d", cycle);
  endtask

  task automatic test_write_then_read();
    do_write(8'hFF, 32'h12345678);
    step();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFF; req_wdata = 32'h0BADF00D; rsp_ready = 1'b1;
    step(); // N+1
    req_valid = 1'b0;
    total_cnt++;
    if ({sram_addr, sram_din, sram_sense_en} !== {8'hFF, 32'h12345678, 1'b0})
      $display("FAIL rd_setup: got %h want %h", {sram_addr, sram_din, sram_sense_en}, {8'hFF, 32'h12345678, 1'b0});
    else pass_cnt++;
    step(); // N+2
    total_cnt++;
    if ({sram_sense_en, sram_write_en, rsp_valid} !== 3'b100)
      $display("FAIL rd_sense1: got %b want 100", {sram_sense_en, sram_write_en, rsp_valid});
    else pass_cnt++;
    step(); // N+3
    total_cnt++;
    if ({sram_sense_en, sram_write_en, rsp_valid} !== 3'b100)
      $display("FAIL rd_sense2: got %b want 100", {sram_sense_en, sram_write_en, rsp_valid});
    else pass_cnt++;
    step(); // N+4
    total_cnt++;
    if ({sram_sense_en, rsp_valid, req_ready} !== 3'b010)
      $display("FAIL rd_rsp_ctrl: got %b want 010", {sram_sense_en, rsp_valid, req_ready});
    else pass_cnt++;
    total_cnt++;
    if (rsp_rdata !== 32'h12345678) $display("FAIL rd_rdata: got %h want 12345678", rsp_rdata);
    else pass_cnt++;
    step(); // N+5
    total_cnt++;
    if ({rsp_valid, req_ready, rsp_rdata} !== {2'b01, 32'h12345678})
      $display("FAIL rd_after: got %h want %h", {rsp_valid, req_ready, rsp_rdata}, {2'b01, 32'h12345678});
    else pass_cnt++;
    $display("read addr=ff data=%h cycle=%0d", rsp_rdata, cycle);
  endtask

  task automatic test_backpressure();
    int n;
    do_write(8'h10, 32'hCAFEF00D);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; rsp_ready = 1'b0;
    step();
    req_addr = 8'h33; req_we = 1'b1; req_wdata = 32'h11111111; // must not be taken
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    total_cnt++;
    if (rsp_valid !== 1'b1) $display("FAIL bp_rsp_arrive: got %b want 1", rsp_valid);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if ({rsp_valid, req_ready, rsp_rdata, sram_addr} !== {2'b10, 32'hCAFEF00D, 8'h10})
        $display("FAIL bp_hold: got %h want %h", {rsp_valid, req_ready, rsp_rdata, sram_addr},
                 {2'b10, 32'hCAFEF00D, 8'h10});
      else pass_cnt++;
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    total_cnt++;
    if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL bp_release: got %b want 01", {rsp_valid, req_ready});
    else pass_cnt++;
    $display("read addr=10 data=%h (backpressured) cycle=%0d", rsp_rdata, cycle);
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int acc_cyc [4];
    int cons_err = 0;
    int ovl_err = 0;
    logic prev_we = 1'b0;
    logic hs;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h00; req_wdata = 32'hA0000000;
    for (int c = 0; c < 16; c++) begin
      if (sram_write_en && prev_we) cons_err++;
      if (sram_write_en && sram_sense_en) ovl_err++;
      prev_we = sram_write_en;
      hs = req_valid && req_ready;
      if (hs) acc_cyc[idx] = cycle;
      step();
      if (hs) begin
        idx++;
        if (idx == 4) req_valid = 1'b0;
        else begin
          req_addr  = 8'(idx);
          req_wdata = 32'hA0000000 + 32'(idx);
        end
      end
    end
    total_cnt++;
    if (idx !== 4) $display("FAIL b2b_accepts: got %0d want 4", idx);
    else pass_cnt++;
    for (int i = 1; i < 4; i++) begin
      total_cnt++;
      if (acc_cyc[i] - acc_cyc[i-1] !== 3)
        $display("FAIL b2b_interval%0d: got %0d want 3", i, acc_cyc[i] - acc_cyc[i-1]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cons_err !== 0) $display("FAIL b2b_we_consecutive: got %0d want 0", cons_err);
    else pass_cnt++;
    total_cnt++;
    if (ovl_err !== 0) $display("FAIL b2b_overlap: got %0d want 0", ovl_err);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (mem[i] !== 32'hA0000000 + 32'(i))
        $display("FAIL b2b_data%0d: got %h want %h", i, mem[i], 32'hA0000000 + 32'(i));
      else pass_cnt++;
      $display("write addr=%02h data=%h accepted cycle=%0d", i, mem[i], acc_cyc[i]);
    end
  endtask

  task automatic test_mid_read_reset();
    int spurious = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; rsp_ready = 1'b1;
    step(); // N+1
    req_valid = 1'b0;
    step(); // N+2, first sense cycle
    total_cnt++;
    if (sram_sense_en !== 1'b1) $display("FAIL mrr_sense_on: got %b want 1", sram_sense_en);
    else pass_cnt++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total_cnt++;
    if ({sram_sense_en, rsp_valid, req_ready, sram_addr} !== {3'b001, 8'h00})
      $display("FAIL mrr_reset: got %h want %h", {sram_sense_en, rsp_valid, req_ready, sram_addr}, {3'b001, 8'h00});
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid || sram_sense_en) spurious++;
    end
    total_cnt++;
    if (spurious !== 0) $display("FAIL mrr_no_response: got %0d want 0", spurious);
    else pass_cnt++;
    $display("read addr=10 aborted by reset cycle=%0d", cycle);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    test_reset();
    test_single_write();
    test_write_then_read();
    test_backpressure();
    test_back_to_back();
    test_mid_read_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Sequencer directly upstream of the 256x32 compiled SRAM array macro.
- Accepts single-word read/write requests on a valid/ready interface.
- Drives the array's address, data-in, write_en and sense_en pins with fixed setup/pulse timing.
- Captures dout at the end of the sense window and returns it on a valid/ready response channel.

Parameters:
- ADDR_W, 8, address width; array depth is 2**ADDR_W.
- DATA_W, 32, word width.
- WR_CYCLES, 1, cycles write_en is held high; legal range 1..15.
- SENSE_CYCLES, 2, cycles sense_en is held high before dout is sampled; legal range 1..15.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  consumer accepts rsp_rdata.
- rsp_rdata  out  DATA_W  captured read word.
- wr_done  out  1  one-cycle pulse when a write completes.
- sram_addr  out  ADDR_W  to array addr pins, bit i = addr i.
- sram_din  out  DATA_W  to array din pins.
- sram_dout  in  DATA_W  from array dout pins.
- sram_write_en  out  1  to array write_en.
- sram_sense_en  out  1  to array sense_en.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- All outputs are registered.
- Reset values:
  - State IDLE, req_ready=1.
  - rsp_valid=0, rsp_rdata=0, wr_done=0.
  - sram_addr=0, sram_din=0.
  - sram_write_en=0, sram_sense_en=0.
- FSM states: IDLE, SETUP, WRITE, SENSE, RESP.
- req_ready=1 only in IDLE. No request is accepted in any other state.
- IDLE: on handshake in cycle N:
  - Register req_addr into sram_addr.
  - If req_we=1, register req_wdata into sram_din; if req_we=0, sram_din holds its previous value.
  - Latch req_we internally and go to SETUP.
- SETUP (cycle N+1): both enables 0; addr/din stable. Next state is WRITE if the latched we=1, else SENSE.
- WRITE: sram_write_en=1 for cycles N+2 .. N+1+WR_CYCLES. Then IDLE with wr_done=1 in cycle N+2+WR_CYCLES (one cycle). A new request may be accepted in that same cycle.
- SENSE: sram_sense_en=1 for cycles N+2 .. N+1+SENSE_CYCLES.
  - sram_dout is sampled into rsp_rdata at the rising edge ending the last sense cycle.
  - Go to RESP with rsp_valid=1 from cycle N+2+SENSE_CYCLES (default N+4).
- RESP:
  - rsp_valid and rsp_rdata are held stable until rsp_valid && rsp_ready.
  - Next cycle: rsp_valid=0, state IDLE.
  - rsp_rdata keeps its value until the next capture.
  - Backpressure of any length is allowed; no request is accepted while in RESP.
- Invariants:
  - sram_write_en and sram_sense_en are never 1 in the same cycle.
  - Both enables are 0 in every SETUP and IDLE cycle, so every transaction has at least one enable-low cycle between enable phases.
  - sram_addr/sram_din change only on an accept edge, never while an enable is high.
- Cycle counter: 4 bits, loaded with WR_CYCLES-1 or SENSE_CYCLES-1 on exit from SETUP, decremented each enable cycle. The phase ends when the counter is 0.
- Reset mid-operation: rst_n=0 at any edge forces the reset values at that edge.
  - Enables drop within that cycle.
  - A pending response is discarded; a partial write is not retried.
- Back-to-back writes: minimum issue interval is 2+WR_CYCLES cycles (default 3).
- Back-to-back reads: minimum issue interval is 3+SENSE_CYCLES cycles (default 5), with rsp_ready held at 1.
- Out-of-range parameter values are a configuration error and are not supported.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> all outputs at reset values, no enable pulse; req_ready=1 on the first cycle after release.
- Single write: addr=0x5A, wdata=0xDEADBEEF accepted at cycle N -> sram_addr=0x5A and sram_din=0xDEADBEEF from N+1; write_en=1 only in N+2; wr_done=1 only in N+3; sense_en never 1.
- Write then read: write 0x12345678 to 0xFF, then read 0xFF with a behavioural array model -> sense_en=1 in N+2..N+3; rsp_valid=1 at N+4 with rsp_rdata=0x12345678.
- Response backpressure: rsp_ready=0 for 6 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; rsp_ready=1 -> rsp_valid=0 and req_ready=1 next cycle.
- Throughput: 4 back-to-back writes to addresses 0..3 with req_valid held high -> accepts every 3 cycles; write_en never high on two consecutive cycles across transactions; enables never overlap.
- Mid-read reset: rst_n=0 during the first sense cycle -> sense_en=0 and rsp_valid=0 from the next cycle; no response is ever produced for that request.
